// File: rtl/priority_to_onehot_arbiter_if.sv
// Request/grant bundle between requesters and the round-robin arbiter.
// The dec_idx field exists only when PRIORITY_TO_ONEHOT_ARBITER_IDX_EN is defined.
interface priority_to_onehot_arbiter_if #(
  parameter int WIDTH = 8
);
  localparam int WIDTH_LOG = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] enc_pry;
  logic [WIDTH-1:0] enc_oht;
  logic [WIDTH-1:0] msk;
  logic             dec_vld;
  logic             dec_rdy;

`ifdef PRIORITY_TO_ONEHOT_ARBITER_IDX_EN
  logic [WIDTH_LOG-1:0] dec_idx;

  modport master (input enc_pry, dec_rdy, output enc_oht, dec_vld, msk, dec_idx);
  modport slave  (output enc_pry, dec_rdy, input enc_oht, dec_vld, msk, dec_idx);
`else
  modport master (input enc_pry, dec_rdy, output enc_oht, dec_vld, msk);
  modport slave  (output enc_pry, dec_rdy, input enc_oht, dec_vld, msk);
`endif
endinterface

// File: rtl/priority_to_onehot_arbiter.sv
// Registered round-robin arbiter: one-hot grant with valid/ready handshake and rotating mask.
// Optional binary grant index output enabled by PRIORITY_TO_ONEHOT_ARBITER_IDX_EN.
module priority_to_onehot_arbiter #(
  parameter int WIDTH          = 8,
  parameter int IMPLEMENTATION = 0
) (
  input  logic                            clk,
  input  logic                            rst,
  priority_to_onehot_arbiter_if.master    bus
);
  localparam int WIDTH_LOG = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state;
  logic [WIDTH-1:0] oht_q;
  logic [WIDTH-1:0] msk_q;

  logic             acc;
  logic [WIDTH-1:0] raw_above;
  logic [WIDTH-1:0] above;
  logic [WIDTH-1:0] msk_nxt;
  logic [WIDTH-1:0] masked;
  logic [WIDTH-1:0] sel_m;
  logic [WIDTH-1:0] sel_u;
  logic [WIDTH-1:0] sel;
  logic             sel_vld;

  assign acc = (state == GRANT) & bus.dec_rdy;

  // Bits strictly above the granted bit; a grant on the top bit wraps to all ones.
  assign raw_above = ~(oht_q | (oht_q - WIDTH'(1)));
  assign above     = (raw_above == '0) ? '1 : raw_above;
  assign msk_nxt   = acc ? above : msk_q;

  assign masked  = bus.enc_pry & msk_nxt;
  assign sel_vld = |bus.enc_pry;

  generate
    if (IMPLEMENTATION == 0) begin : g_adder
      assign sel_m = masked & (~masked + WIDTH'(1));
      assign sel_u = bus.enc_pry & (~bus.enc_pry + WIDTH'(1));
    end else begin : g_loop
      // Scan downward so the lowest set bit is the last write.
      always_comb begin
        sel_m = '0;
        sel_u = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
          if (masked[i]) begin
            sel_m    = '0;
            sel_m[i] = 1'b1;
          end
          if (bus.enc_pry[i]) begin
            sel_u    = '0;
            sel_u[i] = 1'b1;
          end
        end
      end
    end
  endgenerate

  assign sel = (masked != '0) ? sel_m : sel_u;

`ifdef PRIORITY_TO_ONEHOT_ARBITER_IDX_EN
  logic [WIDTH_LOG-1:0] sel_idx;
  logic [WIDTH_LOG-1:0] idx_q;

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (sel[i]) sel_idx = WIDTH_LOG'(i);
    end
  end

  assign bus.dec_idx = idx_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      oht_q <= '0;
      msk_q <= '1;
`ifdef PRIORITY_TO_ONEHOT_ARBITER_IDX_EN
      idx_q <= '0;
`endif
    end else begin
      msk_q <= msk_nxt;
      case (state)
        IDLE: begin
          if (sel_vld) begin
            oht_q <= sel;
            state <= GRANT;
`ifdef PRIORITY_TO_ONEHOT_ARBITER_IDX_EN
            idx_q <= sel_idx;
`endif
          end
        end
        GRANT: begin
          // Grant is sticky until accepted; on accept reload immediately for full throughput.
          if (bus.dec_rdy) begin
            if (sel_vld) begin
              oht_q <= sel;
`ifdef PRIORITY_TO_ONEHOT_ARBITER_IDX_EN
              idx_q <= sel_idx;
`endif
            end else begin
              oht_q <= '0;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.enc_oht = oht_q;
  assign bus.dec_vld = (state == GRANT);
  assign bus.msk     = msk_q;
endmodule

// File: tb/tb_priority_to_onehot_arbiter.sv
// Self-checking bench: both selection implementations run side by side against a pointer-based model.
module tb_priority_to_onehot_arbiter;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] enc_pry;
  logic         dec_rdy;

  int total_checks = 0;
  int pass_checks  = 0;
  int fail_checks  = 0;

  // Reference state: current grant index, valid flag, and last accepted requester (-1 = none).
  int m_vld;
  int m_gidx;
  int m_ptr;

  always #5 clk = ~clk;

  priority_to_onehot_arbiter_if #(.WIDTH(W)) bus0 ();
  priority_to_onehot_arbiter_if #(.WIDTH(W)) bus1 ();

  assign bus0.enc_pry = enc_pry;
  assign bus0.dec_rdy = dec_rdy;
  assign bus1.enc_pry = enc_pry;
  assign bus1.dec_rdy = dec_rdy;

  priority_to_onehot_arbiter #(.WIDTH(W), .IMPLEMENTATION(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.master)
  );

  priority_to_onehot_arbiter #(.WIDTH(W), .IMPLEMENTATION(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.master)
  );

  function automatic int pick(input logic [W-1:0] req, input int ptr);
    for (int i = ptr + 1; i < W; i++) if (req[i]) return i;
    for (int i = 0; i < W; i++) if (req[i]) return i;
    return -1;
  endfunction

  function automatic logic [W-1:0] mask_of(input int ptr);
    logic [W-1:0] m;
    if (ptr < 0 || ptr == W - 1) return '1;
    m = '0;
    for (int i = ptr + 1; i < W; i++) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [W-1:0] exp_oht();
    logic [W-1:0] g;
    g = '0;
    if (m_vld != 0) g[m_gidx] = 1'b1;
    return g;
  endfunction

  task automatic modelReset();
    m_vld  = 0;
    m_gidx = 0;
    m_ptr  = -1;
  endtask

  task automatic modelClock();
    int ptr_n;
    int c;
    ptr_n = (m_vld != 0 && dec_rdy) ? m_gidx : m_ptr;
    if (m_vld == 0 || dec_rdy) begin
      c = pick(enc_pry, ptr_n);
      if (c >= 0) begin
        m_vld  = 1;
        m_gidx = c;
      end else begin
        m_vld = 0;
      end
    end
    m_ptr = ptr_n;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_checks++;
    assert (obs === exp) pass_checks++;
    else begin
      fail_checks++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    check({tag, " oht0"}, 32'(bus0.enc_oht), 32'(exp_oht()));
    check({tag, " vld0"}, 32'(bus0.dec_vld), 32'(m_vld != 0));
    check({tag, " msk0"}, 32'(bus0.msk), 32'(mask_of(m_ptr)));
    check({tag, " oht1"}, 32'(bus1.enc_oht), 32'(exp_oht()));
    check({tag, " vld1"}, 32'(bus1.dec_vld), 32'(m_vld != 0));
    check({tag, " msk1"}, 32'(bus1.msk), 32'(mask_of(m_ptr)));
`ifdef PRIORITY_TO_ONEHOT_ARBITER_IDX_EN
    check({tag, " idx0"}, 32'(bus0.dec_idx), 32'(m_gidx));
    check({tag, " idx1"}, 32'(bus1.dec_idx), 32'(m_gidx));
`endif
  endtask

  task automatic applyStimulus(input logic [W-1:0] pry, input logic rdy, input string tag);
    enc_pry = pry;
    dec_rdy = rdy;
    modelClock();
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  task automatic doReset();
    rst = 1'b1;
    #1;
    modelReset();
    checkOutput("reset_async");
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst     = 1'b0;
    enc_pry = 8'hFF;
    dec_rdy = 1'b0;
    modelReset();
    #3;

    // Reset held with all requests active
    rst = 1'b1;
    #1;
    checkOutput("reset_hold");
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("reset_hold_edges");
    check("reset_msk_lit", 32'(bus0.msk), 32'h0000_00FF);
    rst = 1'b0;

    applyStimulus(8'hFF, 1'b0, "first_grant");
    check("first_grant_lit", 32'(bus0.enc_oht), 32'h0000_0001);

    // Full rotation with constant ready
    for (int i = 1; i <= W; i++) begin
      applyStimulus(8'hFF, 1'b1, "rotate");
      check("rotate_lit", 32'(bus1.enc_oht), 32'(1 << (i % W)));
    end
    check("rotate_wrap_msk_lit", 32'(bus0.msk), 32'h0000_00FF);

    // Sticky grant while stalled
    doReset();
    for (int i = 0; i < 5; i++) applyStimulus(8'h24, 1'b0, "sticky");
    check("sticky_lit", 32'(bus0.enc_oht), 32'h0000_0004);
    applyStimulus(8'h00, 1'b0, "sticky_drop");
    applyStimulus(8'h00, 1'b1, "sticky_accept");
    check("sticky_idle_lit", 32'(bus0.dec_vld), 32'h0);

    // Accept on bit 2 with nothing requested above it wraps to bit 0
    doReset();
    applyStimulus(8'h04, 1'b0, "wrap_setup");
    applyStimulus(8'h05, 1'b1, "wrap_a");
    check("wrap_a_lit", 32'(bus0.enc_oht), 32'h0000_0001);
    applyStimulus(8'h05, 1'b1, "wrap_b");
    check("wrap_b_lit", 32'(bus1.enc_oht), 32'h0000_0004);

    // Asynchronous reset in the middle of a held grant
    doReset();
    applyStimulus(8'h10, 1'b0, "midgrant_setup");
    applyStimulus(8'h30, 1'b0, "midgrant_hold");
    #2;
    rst = 1'b1;
    #1;
    modelReset();
    checkOutput("midgrant_async");
    check("midgrant_oht_lit", 32'(bus1.enc_oht), 32'h0);
    #1;
    rst = 1'b0;
    applyStimulus(8'h30, 1'b1, "post_reset");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [W-1:0] r;
      r = W'($urandom);
      if ($urandom_range(0, 4) == 0) r = '0;
      applyStimulus(r, ($urandom_range(0, 3) != 0), "random");
    end

    $display("%0d/%0d checks passed", pass_checks, total_checks);
    $finish;
  end
endmodule

// File: doc/priority_to_onehot_arbiter.md
Name: priority_to_onehot_arbiter

Overview:
Registered round-robin arbiter built on the rightmost-priority to one-hot conversion. It takes WIDTH request lines and issues a one-hot grant with a valid/ready handshake. A rotating priority mask gives fair service. It sits between multiple requesters and a single shared downstream consumer, such as a bus port or a shared FIFO write side.

Parameters:
WIDTH, 8, number of requesters; must be >= 1
WIDTH_LOG, $clog2(WIDTH) (localparam, 1 when WIDTH=1), width of the binary grant index
IMPLEMENTATION, 0, selection logic for masked and unmasked rightmost-one: 0 = adder (x & -x), 1 = loop

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, asynchronous, active-high
enc_pry  input  WIDTH  request vector; bit i = requester i wants service
enc_oht  output  WIDTH  registered one-hot grant; all zero when dec_vld=0
dec_vld  output  1  grant valid
dec_rdy  input  1  downstream accepts grant; transfer when dec_vld & dec_rdy
msk  output  WIDTH  current round-robin priority mask, for debug/coverage

Behaviour:
- Reset (async assert, sync release): enc_oht=0, dec_vld=0, msk=all ones.
- State machine:
  - IDLE (dec_vld=0).
  - GRANT (dec_vld=1).
- Accept term: acc = dec_vld & dec_rdy.
- Next-mask: msk_nxt = acc ? above(enc_oht) : msk.
  - above(g) has ones strictly above the granted bit position.
  - If the grant is on bit WIDTH-1, above(g) = all ones (wrap-around).
  - msk <= msk_nxt every cycle.
- Selection (combinational):
  - sel = rightmost one of (enc_pry & msk_nxt) when that is non-zero.
  - Otherwise sel = rightmost one of enc_pry.
  - sel_vld = |enc_pry.
- IDLE:
  - If sel_vld, register enc_oht<=sel, dec_vld<=1, go to GRANT.
  - Otherwise stay in IDLE.
  - Latency: request at cycle n gives dec_vld=1 at cycle n+1.
- GRANT, !dec_rdy:
  - Hold enc_oht and dec_vld stable.
  - The grant is sticky: it holds even if the granted request drops or higher-priority requests arrive.
  - msk is unchanged.
- GRANT, dec_rdy (accept):
  - Same edge: if sel_vld, enc_oht<=sel and stay in GRANT; this gives back-to-back throughput of 1 grant/cycle.
  - Otherwise enc_oht<=0, dec_vld<=0, go to IDLE.
- A requester whose request is still asserted in its own accept cycle is re-granted only if no requester above it or wrapping below it is asserted. This is the fairness rule.
- Simultaneous accept and new request: handled by msk_nxt. The new selection always sees the post-accept mask.
- Reset mid-grant: immediately clears dec_vld/enc_oht and restores the mask. The in-flight grant is dropped and does not count as accepted.
- WIDTH=1: msk is constant 1; the block degenerates to a registered valid/ready stage for the single request.
- enc_oht is always one-hot or zero. It is zero iff dec_vld=0.
- Both IMPLEMENTATION values are cycle-identical.

Optional Feature:
Macro PRIORITY_TO_ONEHOT_ARBITER_IDX_EN.
- When defined:
  - Adds output dec_idx [WIDTH_LOG-1:0], the binary index of the bit set in enc_oht.
  - It is registered in the same edge as enc_oht.
  - It resets to 0 and holds its value while dec_vld=0.
- When undefined:
  - The port and its logic are absent.
  - Ports and timing are otherwise identical.

Test Plan:
- Reset with WIDTH=8, enc_pry=8'hFF held during reset → enc_oht=0, dec_vld=0, msk=8'hFF; first cycle after release gives enc_oht=8'h01, dec_vld=1.
- enc_pry=8'hFF, dec_rdy=1 constant → grants rotate 01,02,04,…,80,01 on consecutive cycles; msk after the 80 grant is FF.
- enc_pry=8'h24, dec_rdy=0 for 5 cycles, then enc_pry drops to 8'h00 → enc_oht stays 8'h04 for all 5 cycles; after dec_rdy=1 it is accepted and the block returns to IDLE (dec_vld=0 next cycle).
- Grant on bit 2 accepted while enc_pry=8'h05 → next grant 8'h01 (wrap, no request above bit 2), then 8'h04.
- Async rst pulse mid-GRANT (enc_oht=8'h10) → outputs zero without waiting for a clock edge, msk=FF; run for IMPLEMENTATION=0 and 1 with a cycle-compare scoreboard.
- With PRIORITY_TO_ONEHOT_ARBITER_IDX_EN, WIDTH=5, enc_pry=5'b10000 → dec_idx=4 aligned with enc_oht=5'b10000; without the macro, the build succeeds and the port is absent.
